bus_if_unit: RTL and testbench
==============================

BUS_IF_UNIT -- requirements
Module: bus_if_unit

Interface
REQ-001 Parameter DATA_W, default 8, data bus width in bits.
REQ-002 Parameter ADDR_W, default 8, address bus width in bits.
REQ-003 Parameter MAX_WAIT, default 15, maximum wait cycles before timeout; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req  input  1  core transfer request, sampled only in IDLE.
REQ-007 we  input  1  1 = write, 0 = read; qualified by req.
REQ-008 req_addr  input  ADDR_W  transfer address.
REQ-009 req_wdata  input  DATA_W  write data.
REQ-010 ack  output  1  one-cycle pulse: transfer finished, either done or timed out.
REQ-011 err  output  1  one-cycle pulse coincident with ack when the transfer timed out.
REQ-012 rdata  output  DATA_W  read data, valid while ack=1 and err=0, then held.
REQ-013 rd  output  1  bus read strobe.
REQ-014 wrt  output  1  bus write strobe.
REQ-015 add  output  ADDR_W  bus address.
REQ-016 dat  inout  DATA_W  bidirectional bus data.
REQ-017 rdy  input  1  memory ready, sampled synchronously.

Function
REQ-018 FSM states are IDLE, SETUP, ACCESS, DONE and ERR.
REQ-019 In IDLE with req=1, the block SHALL latch we, req_addr and req_wdata and move to SETUP; req in any other state is ignored.
REQ-020 SETUP lasts exactly one cycle: add = latched address, rd=wrt=0, dat driven with latched wdata only for writes; next state ACCESS.
REQ-021 ACCESS: rd=1 for reads or wrt=1 for writes, never both; add held; dat driven only for writes, high-Z otherwise.
REQ-022 In ACCESS, rdy=1 at a clock edge SHALL move to DONE; for reads, dat is captured into rdata at that same edge.
REQ-023 The wait counter clears on entry to ACCESS and increments each ACCESS cycle with rdy=0; when it reaches MAX_WAIT with rdy=0, the next state is ERR.
REQ-024 rdy=1 on the cycle the counter reaches MAX_WAIT SHALL complete normally (DONE); ready has priority over timeout.
REQ-025 DONE: ack=1, err=0, strobes low, dat high-Z; next state IDLE.
REQ-026 ERR: ack=1, err=1, strobes low, dat high-Z, rdata unchanged; next state IDLE.
REQ-027 Minimum latency: req sampled at edge N gives ack=1 in the cycle after edge N+2 (rdy already high in ACCESS).
REQ-028 Back-to-back: req held through DONE/ERR is accepted at the first IDLE edge; maximum throughput is one transfer per 4 cycles.
REQ-029 dat SHALL be high-Z in every state except SETUP and ACCESS of a write.
REQ-030 add SHALL hold the last transfer address in IDLE, DONE and ERR.

Reset
REQ-031 rst=0 SHALL immediately force IDLE, rd=0, wrt=0, ack=0, err=0, add=0, rdata=0, wait counter=0 and dat high-Z, including in the middle of a transfer.
REQ-032 An aborted transfer SHALL produce no ack; the first request after reset release is sampled at the first rising edge with rst=1.

Structure
REQ-033 Package bus_if_pkg SHALL hold the FSM state enum and the default width constants.
REQ-034 The wait counter SHALL be a sub-module wait_timer (clear, enable, terminal-count output), sized $clog2(MAX_WAIT+1).
REQ-035 The tri-state driver SHALL be a single continuous assignment gated by a registered drive-enable.

Verification
REQ-036 Read with rdy tied high, addr=0x3C, memory returns 0xA5 -> rd high for 1 cycle; ack with rdata=0xA5 and err=0, 3 cycles after req.
REQ-037 Write with addr=0x10, data=0x5A, rdy delayed 4 cycles -> wrt high for 5 cycles; dat=0x5A during SETUP and ACCESS, then Z; single ack.
REQ-038 Read with MAX_WAIT=15 and rdy never asserted -> ack=err=1 after 15 wait cycles; rdata unchanged; rd drops.
REQ-039 rdy rises exactly on the terminal wait cycle -> DONE taken, err=0.
REQ-040 rst asserted mid-ACCESS of a write -> wrt=0 and dat=Z with no clock edge; no ack; a new read after release completes normally.
REQ-041 Run 1000 random back-to-back reads and writes at DATA_W=16 and ADDR_W=12 against a memory model -> all read data matches, and rd/wrt are never high together.

Source files
------------

// File: rtl/bus_if_pkg.sv
// bus_if_pkg: shared types and default sizes for the bus interface unit.
//   state_t       - transfer FSM state encoding
//   DEF_DATA_W    - default data bus width
//   DEF_ADDR_W    - default address bus width
//   DEF_MAX_WAIT  - default number of wait cycles before a transfer times out
package bus_if_pkg;

   localparam int DEF_DATA_W   = 8;
   localparam int DEF_ADDR_W   = 8;
   localparam int DEF_MAX_WAIT = 15;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ACCESS = 3'd2,
      DONE   = 3'd3,
      ERR    = 3'd4
   } state_t;

endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts the ACCESS cycles spent waiting for the memory.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear (takes priority over en)
//   en       : count one wait cycle
//   tc       : terminal count, high while the count equals MAX_WAIT
module wait_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] cnt;

   assign tc = (cnt == CNT_W'(MAX_WAIT));

   // Saturates at MAX_WAIT so the count can never wrap back to zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)              cnt <= '0;
      else if (clr)          cnt <= '0;
      else if (en && !tc)    cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/bus_if_unit.sv
// bus_if_unit: turns a single core request into a strobed bus transfer with a
// one-cycle setup phase, a ready-terminated access phase and a wait timeout.
//   clk, rst            : clock, asynchronous active-low reset
//   req, we             : transfer request (sampled only in IDLE), write select
//   req_addr, req_wdata : transfer address and write data
//   ack, err            : completion pulse, timeout flag (coincident with ack)
//   rdata               : read data, updated when a read completes, else held
//   rd, wrt, add        : bus read strobe, write strobe, address
//   dat                 : bidirectional bus data, driven only for writes
//   rdy                 : memory ready
module bus_if_unit
   import bus_if_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              ack,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic              rd,
   output logic              wrt,
   output logic [ADDR_W-1:0] add,
   inout  wire  [DATA_W-1:0] dat,
   input  logic              rdy
);

   state_t            state;
   state_t            nxt;
   logic              we_q;
   logic [DATA_W-1:0] wdata_q;
   logic              dat_oe;
   logic              tc;
   logic              accept;

   assign accept = (state == IDLE) && req;

   // The timer clears while in SETUP so it reads zero on the first ACCESS cycle.
   wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
      .clk (clk),
      .rst (rst),
      .clr (state == SETUP),
      .en  ((state == ACCESS) && !rdy),
      .tc  (tc)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   // Next state: ready wins over the timeout on the terminal cycle.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:     if (req) nxt = SETUP;
         SETUP:    nxt = ACCESS;
         ACCESS:   if (rdy)     nxt = DONE;
                   else if (tc) nxt = ERR;
         DONE,
         ERR:      nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end

   // Outputs decoded from the state register; reset forces them low at once.
   always_comb begin
      rd  = 1'b0;
      wrt = 1'b0;
      ack = 1'b0;
      err = 1'b0;
      case (state)
         ACCESS: begin
            rd  = !we_q;
            wrt = we_q;
         end
         DONE:   ack = 1'b1;
         ERR: begin
            ack = 1'b1;
            err = 1'b1;
         end
         default: ;
      endcase
   end

   // Request latch, read capture and registered drive-enable. The enable is
   // computed from the next state so it is high exactly in SETUP/ACCESS of a
   // write; 'we' is used directly on the accept edge since we_q is not yet loaded.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q    <= 1'b0;
         wdata_q <= '0;
         add     <= '0;
         rdata   <= '0;
         dat_oe  <= 1'b0;
      end else begin
         if (accept) begin
            we_q    <= we;
            wdata_q <= req_wdata;
            add     <= req_addr;
         end
         if ((state == ACCESS) && rdy && !we_q)
            rdata <= dat;
         dat_oe <= (nxt == SETUP)  ? we   :
                   (nxt == ACCESS) ? we_q : 1'b0;
      end
   end

   assign dat = dat_oe ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_if_unit.sv
`timescale 1ns/1ps
module tb_bus_if_unit;

   localparam int DW = 16;
   localparam int AW = 12;
   localparam int MW = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req = 1'b0;
   logic          we  = 1'b0;
   logic          rdy = 1'b0;
   logic [AW-1:0] req_addr  = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          ack, err, rd, wrt;
   logic [DW-1:0] rdata;
   logic [AW-1:0] add;
   wire  [DW-1:0] dat;

   // Probe drive lets the bench prove dat is released: a released bus reads
   // back exactly what the probe drives.
   logic          probe_en  = 1'b0;
   logic [DW-1:0] probe_val = '0;

   logic [DW-1:0] mem     [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];

   int n_asrt = 0;
   int n_fail = 0;

   int            r_cyc, r_strb, r_datbad, r_addbad;
   int            r_both = 0;
   logic          r_err, r_ack;
   logic [DW-1:0] r_rdata;

   bus_if_unit #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .we        (we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .ack       (ack),
      .err       (err),
      .rdata     (rdata),
      .rd        (rd),
      .wrt       (wrt),
      .add       (add),
      .dat       (dat),
      .rdy       (rdy)
   );

   always #5 clk = ~clk;

   assign dat = probe_en ? probe_val : (rd ? mem[add] : {DW{1'bz}});

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_z(input string tag);
      probe_en  = 1'b1;
      probe_val = '0;
      #1;
      chk({tag, "_z0"}, 32'(dat), 32'h0);
      probe_val = '1;
      #1;
      chk({tag, "_z1"}, 32'(dat), 32'hFFFF);
      probe_en = 1'b0;
      #1;
   endtask

   // One transfer, called at a negedge; returns at the negedge where ack is seen.
   // rdy rises after 'dly' waiting ACCESS cycles; writes land in mem on rdy.
   task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int dly, input bit keep);
      logic [DW-1:0] prev_dat;
      r_cyc = 0; r_strb = 0; r_datbad = 0; r_addbad = 0;
      prev_dat = dat;
      req = 1'b1; we = w; req_addr = a; req_wdata = d; rdy = 1'b0;
      do begin
         @(negedge clk);
         r_cyc++;
         if (rd && wrt) r_both++;
         if (rd || wrt) begin
            if (r_strb == 0 && w && prev_dat !== d) r_datbad++;
            r_strb++;
            if (w && dat !== d) r_datbad++;
            if (add !== a) r_addbad++;
            if (!keep) req = 1'b0;
            rdy = (r_strb - 1 >= dly);
            if (w && rdy) mem[add] = dat;
         end else begin
            rdy = 1'b0;
         end
         prev_dat = dat;
      end while (!ack && r_cyc < 100);
      r_ack = ack; r_err = err; r_rdata = rdata;
   endtask

   initial begin
      int bad_rd, bad_lat, bad_dat, bad_add, bad_err;
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i]     = DW'(i * 7 + 3);
         ref_mem[i] = DW'(i * 7 + 3);
      end
      mem[12'h03C]     = 16'h00A5;
      ref_mem[12'h03C] = 16'h00A5;

      // Reset state
      #3;
      chk("rst_rd", 32'(rd), 0);
      chk("rst_wrt", 32'(wrt), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_add", 32'(add), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk_z("rst");
      @(negedge clk);
      rst = 1'b1;

      // Read, rdy high: ack 3 cycles after req, one rd cycle
      xfer(1'b0, 12'h03C, '0, 0, 1'b0);
      chk("rd_lat", 32'(r_cyc), 3);
      chk("rd_strb", 32'(r_strb), 1);
      chk("rd_ack", 32'(r_ack), 1);
      chk("rd_err", 32'(r_err), 0);
      chk("rd_data", 32'(r_rdata), 32'h00A5);
      chk("rd_addbad", 32'(r_addbad), 0);
      chk_z("rd_done");
      @(negedge clk);
      chk("rd_idle_ack", 32'(ack), 0);
      chk("rd_idle_add", 32'(add), 32'h03C);
      chk("rd_idle_rdata", 32'(rdata), 32'h00A5);

      // Write, rdy after 4 waits: 5 wrt cycles, dat valid in SETUP and ACCESS
      xfer(1'b1, 12'h010, 16'h005A, 4, 1'b0);
      chk("wr_lat", 32'(r_cyc), 7);
      chk("wr_strb", 32'(r_strb), 5);
      chk("wr_ack", 32'(r_ack), 1);
      chk("wr_err", 32'(r_err), 0);
      chk("wr_datbad", 32'(r_datbad), 0);
      chk_z("wr_done");
      ref_mem[12'h010] = 16'h005A;
      @(negedge clk);
      chk("wr_single_ack", 32'(ack), 0);
      chk("wr_idle_add", 32'(add), 32'h010);

      // Read back the written word
      xfer(1'b0, 12'h010, '0, 2, 1'b0);
      chk("rb_strb", 32'(r_strb), 3);
      chk("rb_data", 32'(r_rdata), 32'h005A);
      @(negedge clk);

      // Timeout: 15 counted waits, then ERR on the terminal cycle
      xfer(1'b0, 12'h020, '0, 1000, 1'b0);
      chk("to_lat", 32'(r_cyc), 18);
      chk("to_strb", 32'(r_strb), 16);
      chk("to_ack", 32'(r_ack), 1);
      chk("to_err", 32'(r_err), 1);
      chk("to_rdata", 32'(r_rdata), 32'h005A);
      chk_z("to_err");
      @(negedge clk);
      chk("to_rd_drop", 32'(rd), 0);
      chk("to_err_pulse", 32'(err), 0);
      chk("to_ack_pulse", 32'(ack), 0);

      // rdy on the terminal cycle: ready wins
      xfer(1'b0, 12'h021, '0, 15, 1'b0);
      chk("tc_strb", 32'(r_strb), 16);
      chk("tc_err", 32'(r_err), 0);
      chk("tc_ack", 32'(r_ack), 1);
      chk("tc_data", 32'(r_rdata), 32'(DW'(12'h021 * 7 + 3)));
      @(negedge clk);

      // Back-to-back with req held: one transfer per 4 cycles
      xfer(1'b1, 12'h030, 16'h1234, 0, 1'b1);
      chk("b2b_wr_lat", 32'(r_cyc), 3);
      ref_mem[12'h030] = 16'h1234;
      xfer(1'b0, 12'h030, '0, 0, 1'b0);
      chk("b2b_rd_lat", 32'(r_cyc), 4);
      chk("b2b_rd_data", 32'(r_rdata), 32'h1234);
      @(negedge clk);

      // Reset in the middle of a write ACCESS
      req = 1'b1; we = 1'b1; req_addr = 12'h040; req_wdata = 16'hBEEF; rdy = 1'b0;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      chk("ab_wrt_on", 32'(wrt), 1);
      chk("ab_dat_on", 32'(dat), 32'hBEEF);
      #2;
      rst = 1'b0;
      #1;
      chk("ab_wrt", 32'(wrt), 0);
      chk("ab_ack", 32'(ack), 0);
      chk("ab_add", 32'(add), 0);
      chk("ab_rdata", 32'(rdata), 0);
      chk_z("ab");
      @(negedge clk);
      chk("ab_no_ack", 32'(ack), 0);
      chk("ab_wrt_low", 32'(wrt), 0);
      rst = 1'b1;
      xfer(1'b0, 12'h03C, '0, 0, 1'b0);
      chk("ab_rel_lat", 32'(r_cyc), 3);
      chk("ab_rel_data", 32'(r_rdata), 32'h00A5);

      // Random back-to-back traffic against the reference memory
      bad_rd = 0; bad_lat = 0; bad_dat = 0; bad_add = 0; bad_err = 0;
      for (int i = 0; i < 1000; i++) begin
         logic          w;
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         int            dly;
         w   = 1'($urandom_range(0, 1));
         a   = AW'($urandom_range(0, (1 << AW) - 1));
         d   = DW'($urandom);
         dly = int'($urandom_range(0, 3));
         xfer(w, a, d, dly, (i != 999));
         if (r_cyc != 4 + dly) bad_lat++;
         if (!r_ack || r_err) bad_err++;
         bad_dat += r_datbad;
         bad_add += r_addbad;
         if (w) ref_mem[a] = d;
         else if (r_rdata !== ref_mem[a]) bad_rd++;
      end
      req = 1'b0;
      chk("rnd_rdata", 32'(bad_rd), 0);
      chk("rnd_latency", 32'(bad_lat), 0);
      chk("rnd_ack_err", 32'(bad_err), 0);
      chk("rnd_wdata", 32'(bad_dat), 0);
      chk("rnd_addr", 32'(bad_add), 0);
      chk("rd_wrt_overlap", 32'(r_both), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
